// File: rtl/fifo_wr.sv
// Write-side control of an asynchronous FIFO: binary/Gray write pointer,
// two-flop synchronizer for the incoming Gray read pointer, and registered
// full / almost_full / level flags plus a sticky overflow flag.
//
// Producer handshake: a write is accepted on a rising w_clk edge when
// winc=1 and full=0 (w_en=1 in that cycle); winc=1 while full=1 is rejected,
// leaves all pointer and RAM state untouched and sets overflow.
module fifo_wr #(
    parameter int DEPTH      = 8,
    parameter int ADDR_WIDTH = $clog2(DEPTH),
    parameter int AF_MARGIN  = 2
) (
    input  logic                  w_clk,
    input  logic                  w_rst,
    input  logic                  winc,
    input  logic [ADDR_WIDTH:0]   rptr,
    input  logic                  clr_ovf,
    output logic                  w_en,
    output logic [ADDR_WIDTH-1:0] w_addr,
    output logic [ADDR_WIDTH:0]   wptr,
    output logic                  full,
    output logic                  almost_full,
    output logic [ADDR_WIDTH:0]   level,
    output logic                  overflow
);

    localparam int AW = ADDR_WIDTH;
    // Threshold on used entries at which almost_full asserts.
    localparam logic [AW:0] AF_THRESH = (AW+1)'(DEPTH - AF_MARGIN);

    logic [AW:0] wbin_q, wbin_d;
    logic [AW:0] wptr_q, wgray_d;
    logic [AW:0] wq1_q, wq2_q;
    logic [AW:0] wq2_bin;
    logic [AW:0] used_d;
    logic        full_q, full_d;
    logic        almost_full_q, almost_full_d;
    logic [AW:0] level_q;
    logic        ovf_q, ovf_d;

    // Next-state of the write pointer and the flags derived from it.
    always_comb begin
        w_en    = winc & ~full_q;
        wbin_d  = wbin_q + {{AW{1'b0}}, w_en};
        wgray_d = (wbin_d >> 1) ^ wbin_d;
        // Gray-to-binary: bit i is the XOR of all Gray bits from MSB down to i.
        wq2_bin = '0;
        for (int i = 0; i <= AW; i++) begin
            wq2_bin[i] = ^(wq2_q >> i);
        end
        // Full when the next write pointer equals the read pointer with the
        // two top Gray bits inverted (writer one lap ahead of reader).
        full_d        = (wgray_d == {~wq2_q[AW:AW-1], wq2_q[AW-2:0]});
        used_d        = wbin_d - wq2_bin;
        almost_full_d = (used_d >= AF_THRESH);
        // Sticky overflow: a new rejected write wins over a clear request.
        ovf_d = ovf_q;
        if (winc && full_q) begin
            ovf_d = 1'b1;
        end else if (clr_ovf) begin
            ovf_d = 1'b0;
        end
    end

    // Two-flop synchronizer: the only place rptr is sampled.
    always_ff @(posedge w_clk or posedge w_rst) begin
        if (w_rst) begin
            wq1_q <= '0;
            wq2_q <= '0;
        end else begin
            wq1_q <= rptr;
            wq2_q <= wq1_q;
        end
    end

    // Pointer, flag and level registers.
    always_ff @(posedge w_clk or posedge w_rst) begin
        if (w_rst) begin
            wbin_q        <= '0;
            wptr_q        <= '0;
            full_q        <= 1'b0;
            almost_full_q <= 1'b0;
            level_q       <= '0;
            ovf_q         <= 1'b0;
        end else begin
            wbin_q        <= wbin_d;
            wptr_q        <= wgray_d;
            full_q        <= full_d;
            almost_full_q <= almost_full_d;
            level_q       <= used_d;
            ovf_q         <= ovf_d;
        end
    end

    assign w_addr      = wbin_q[AW-1:0];
    assign wptr        = wptr_q;
    assign full        = full_q;
    assign almost_full = almost_full_q;
    assign level       = level_q;
    assign overflow    = ovf_q;

endmodule

// File: tb/tb_fifo_wr.sv
// Self-checking bench for fifo_wr (DEPTH=8, AF_MARGIN=2). Expected write
// addresses are queued when a write is driven and popped when the DUT
// asserts w_en; scenario tasks check flags and pointers inline.
module tb_fifo_wr;

    localparam int DEPTH = 8;
    localparam int AW    = 3;

    logic          w_clk = 1'b0;
    logic          w_rst;
    logic          winc;
    logic [AW:0]   rptr;
    logic          clr_ovf;
    logic          w_en;
    logic [AW-1:0] w_addr;
    logic [AW:0]   wptr;
    logic          full;
    logic          almost_full;
    logic [AW:0]   level;
    logic          overflow;

    int total = 0;
    int bad   = 0;

    logic [AW-1:0] exp_q[$];
    logic [AW:0]   m_wbin;

    fifo_wr #(.DEPTH(DEPTH), .AF_MARGIN(2)) dut (
        .w_clk       (w_clk),
        .w_rst       (w_rst),
        .winc        (winc),
        .rptr        (rptr),
        .clr_ovf     (clr_ovf),
        .w_en        (w_en),
        .w_addr      (w_addr),
        .wptr        (wptr),
        .full        (full),
        .almost_full (almost_full),
        .level       (level),
        .overflow    (overflow)
    );

    // clock / watchdog
    always #5 w_clk = ~w_clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [AW:0] gray(input logic [AW:0] b);
        return (b >> 1) ^ b;
    endfunction

    // scoreboard: every accepted write must present the next expected address
    always @(negedge w_clk) begin
        if (!w_rst && w_en) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL sb_addr: unexpected w_en, w_addr=%0d, queue empty", w_addr);
            end else begin
                logic [AW-1:0] e;
                e = exp_q.pop_front();
                if (w_addr !== e) begin
                    bad++;
                    $display("FAIL sb_addr: w_addr=%0d expected %0d", w_addr, e);
                end
            end
        end
    end

    // driver tasks (inputs change 1 time unit after the rising edge)
    task automatic step();
        @(posedge w_clk);
        #1;
    endtask

    task automatic drive_write(input bit accept);
        winc = 1'b1;
        if (accept) begin
            exp_q.push_back(m_wbin[AW-1:0]);
            m_wbin = m_wbin + 1'b1;
        end
    endtask

    task automatic do_reset();
        winc = 1'b0;
        clr_ovf = 1'b0;
        rptr = '0;
        w_rst = 1'b1;
        step();
        step();
        w_rst = 1'b0;
        m_wbin = '0;
        exp_q.delete();
    endtask

    task automatic test_reset();
        winc = 1'b1;
        clr_ovf = 1'b0;
        rptr = '0;
        w_rst = 1'b1;
        step();
        step();
        total++;
        if ({wptr, w_addr, full, level, overflow, almost_full, w_en} !== {4'd0, 3'd0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1}) begin
            bad++;
            $display("FAIL reset_vals: wptr=%b w_addr=%0d full=%b level=%0d ovf=%b af=%b w_en=%b expected 0,0,0,0,0,0,1",
                     wptr, w_addr, full, level, overflow, almost_full, w_en);
        end
        winc = 1'b0;
        w_rst = 1'b0;
        m_wbin = '0;
        #2;
        total++;
        if ({wptr, level, full} !== 9'd0) begin
            bad++;
            $display("FAIL reset_hold: wptr=%b level=%0d full=%b expected zeros before first edge", wptr, level, full);
        end
    endtask

    task automatic test_fill();
        for (int k = 1; k <= DEPTH; k++) begin
            drive_write(1'b1);
            step();
            total++;
            if (level !== 4'(k) || almost_full !== (k >= 6) || full !== (k == DEPTH)) begin
                bad++;
                $display("FAIL fill_flags[%0d]: level=%0d af=%b full=%b expected %0d %b %b",
                         k, level, almost_full, full, k, (k >= 6), (k == DEPTH));
            end
        end
        winc = 1'b0;
        total++;
        if (wptr !== 4'b1100) begin
            bad++;
            $display("FAIL fill_wptr: wptr=%b expected 1100", wptr);
        end
    endtask

    task automatic test_overflow();
        drive_write(1'b0);
        #2;
        total++;
        if (w_en !== 1'b0) begin
            bad++;
            $display("FAIL ovf_wen: w_en=%b expected 0 while full", w_en);
        end
        step();
        winc = 1'b0;
        total++;
        if (overflow !== 1'b1 || wptr !== 4'b1100 || level !== 4'd8) begin
            bad++;
            $display("FAIL ovf_set: ovf=%b wptr=%b level=%0d expected 1 1100 8", overflow, wptr, level);
        end
        step();
        total++;
        if (overflow !== 1'b1) begin
            bad++;
            $display("FAIL ovf_sticky: ovf=%b expected 1", overflow);
        end
        clr_ovf = 1'b1;
        step();
        clr_ovf = 1'b0;
        total++;
        if (overflow !== 1'b0) begin
            bad++;
            $display("FAIL ovf_clear: ovf=%b expected 0", overflow);
        end
    endtask

    task automatic test_read_release();
        rptr = gray(4'd2);
        step();
        step();
        total++;
        if (full !== 1'b1 || level !== 4'd8) begin
            bad++;
            $display("FAIL sync_delay: full=%b level=%0d after 2 edges expected 1 8", full, level);
        end
        step();
        total++;
        if (full !== 1'b0 || level !== 4'd6 || almost_full !== 1'b1) begin
            bad++;
            $display("FAIL release: full=%b level=%0d af=%b expected 0 6 1", full, level, almost_full);
        end
    endtask

    task automatic test_wrap();
        bit saw_full;
        saw_full = 1'b0;
        do_reset();
        for (int i = 0; i < 2 * DEPTH; i++) begin
            drive_write(1'b1);
            step();
            winc = 1'b0;
            saw_full |= full;
            rptr = gray(4'(i + 1));
            for (int j = 0; j < 3; j++) begin
                step();
                saw_full |= full;
            end
        end
        total++;
        if (saw_full !== 1'b0) begin
            bad++;
            $display("FAIL wrap_full: full asserted=%b expected never", saw_full);
        end
        total++;
        if (wptr !== 4'd0 || w_addr !== 3'd0 || overflow !== 1'b0 || level !== 4'd0) begin
            bad++;
            $display("FAIL wrap_end: wptr=%b w_addr=%0d ovf=%b level=%0d expected 0 0 0 0", wptr, w_addr, overflow, level);
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        for (int k = 0; k < 5; k++) begin
            drive_write(1'b1);
            step();
        end
        winc = 1'b0;
        total++;
        if (level !== 4'd5 || wptr !== gray(4'd5)) begin
            bad++;
            $display("FAIL pre_rst: level=%0d wptr=%b expected 5 %b", level, wptr, gray(4'd5));
        end
        #2;
        w_rst = 1'b1;
        #1;
        total++;
        if ({wptr, w_addr, full, almost_full, level, overflow} !== 14'd0) begin
            bad++;
            $display("FAIL async_rst: wptr=%b w_addr=%0d full=%b af=%b level=%0d ovf=%b expected all 0",
                     wptr, w_addr, full, almost_full, level, overflow);
        end
        #1;
        w_rst = 1'b0;
        m_wbin = '0;
        step();
        total++;
        if (level !== 4'd0 || wptr !== 4'd0) begin
            bad++;
            $display("FAIL post_rst: level=%0d wptr=%b expected 0 0", level, wptr);
        end
    endtask

    initial begin
        w_rst = 1'b0;
        winc = 1'b0;
        clr_ovf = 1'b0;
        rptr = '0;
        m_wbin = '0;
        test_reset();
        test_fill();
        test_overflow();
        test_read_release();
        test_wrap();
        test_async_reset();
        step();
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL sb_drain: %0d writes never seen, expected 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
